// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// gshare_predictor
//   Gshare conditional-branch direction predictor. A pattern history table
//   (PHT) of 2-bit saturating counters is indexed by PC XOR the global
//   history register (GHR). The GHR is shifted speculatively when a
//   prediction is consumed, and repaired from the captured history when a
//   resolved branch reports a misprediction.
//
// Parameters
//   PC_BITS   : width of predict_pc / train_pc (must equal HIST_BITS)
//   HIST_BITS : GHR width; the PHT holds 2**HIST_BITS counters
//   CNT_INIT  : reset value of every PHT counter (01 = weakly not-taken)
//
// Ports
//   clk                : system clock, all state changes on the rising edge
//   rst_n              : asynchronous reset, active-high despite the name
//   predict_valid      : a prediction is consumed this cycle (shifts GHR)
//   predict_pc         : PC of the branch being predicted
//   predict_taken      : predicted direction, combinational
//   predict_history    : GHR value used for this prediction, combinational
//   train_valid        : a resolved branch is trained this cycle
//   train_taken        : actual resolved direction
//   train_mispredicted : resolved direction differed from the prediction
//   train_history      : predict_history captured at prediction time
//   train_pc           : PC of the resolved branch
// ---------------------------------------------------------------------------
module gshare_predictor #(
  parameter int          PC_BITS   = 7,
  parameter int          HIST_BITS = 7,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 predict_valid,
  input  logic [PC_BITS-1:0]   predict_pc,
  output logic                 predict_taken,
  output logic [HIST_BITS-1:0] predict_history,
  input  logic                 train_valid,
  input  logic                 train_taken,
  input  logic                 train_mispredicted,
  input  logic [HIST_BITS-1:0] train_history,
  input  logic [PC_BITS-1:0]   train_pc
);

  localparam int PHT_SIZE = 1 << HIST_BITS;

  logic [HIST_BITS-1:0] r_ghr;
  logic [1:0]           r_pht [PHT_SIZE];

  logic [HIST_BITS-1:0] w_pidx;
  logic [HIST_BITS-1:0] w_tidx;
  logic [1:0]           w_predCnt;
  logic [1:0]           w_trainCnt;
  logic [1:0]           w_trainNext;
  logic                 w_recover;

  // Prediction path is purely combinational; it reads the pre-edge counter,
  // so a same-cycle train of the same entry is not visible until next cycle.
  assign w_pidx          = predict_pc ^ r_ghr;
  assign w_predCnt       = r_pht[w_pidx];
  assign predict_taken   = w_predCnt[1];
  assign predict_history = r_ghr;

  // Training indexes with the history captured at prediction time, not the
  // current (possibly further-shifted) GHR.
  assign w_tidx     = train_pc ^ train_history;
  assign w_trainCnt = r_pht[w_tidx];
  assign w_recover  = train_valid & train_mispredicted;

  // Saturating increment / decrement of the trained counter.
  always_comb begin
    w_trainNext = w_trainCnt;
    if (train_taken) begin
      if (w_trainCnt != 2'b11) w_trainNext = w_trainCnt + 2'b01;
    end else begin
      if (w_trainCnt != 2'b00) w_trainNext = w_trainCnt - 2'b01;
    end
  end

  // GHR: a misprediction rebuilds history from the captured value plus the
  // real outcome, discarding any speculative shift requested this cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ghr <= '0;
    end else if (w_recover) begin
      r_ghr <= {train_history[HIST_BITS-2:0], train_taken};
    end else if (predict_valid) begin
      r_ghr <= {r_ghr[HIST_BITS-2:0], predict_taken};
    end
  end

  // PHT: every counter returns to CNT_INIT on reset; one entry trained per
  // cycle at most.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < PHT_SIZE; i++) begin
        r_pht[i] <= CNT_INIT;
      end
    end else if (train_valid) begin
      r_pht[w_tidx] <= w_trainNext;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_predictor
//   Drives directed and random traffic into gshare_predictor. Every consumed
//   prediction pushes its expected direction and history, taken from a
//   behavioural table/history model, into a queue; a monitor pops and
//   compares whenever a prediction is presented.
// ---------------------------------------------------------------------------
module tb_gshare_predictor;

  logic       clk;
  logic       rst_n;
  logic       predictValid;
  logic [6:0] predictPc;
  logic       predictTaken;
  logic [6:0] predictHistory;
  logic       trainValid;
  logic       trainTaken;
  logic       trainMispredicted;
  logic [6:0] trainHistory;
  logic [6:0] trainPc;

  int compared;
  int mismatched;

  // Behavioural model: plain integer table and history.
  int modelPht [128];
  int modelGhr;

  // Expected {taken, history} per consumed prediction.
  logic [7:0] expQ [$];

  gshare_predictor #(
    .PC_BITS  (7),
    .HIST_BITS(7),
    .CNT_INIT (2'b01)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .predict_valid     (predictValid),
    .predict_pc        (predictPc),
    .predict_taken     (predictTaken),
    .predict_history   (predictHistory),
    .train_valid       (trainValid),
    .train_taken       (trainTaken),
    .train_mispredicted(trainMispredicted),
    .train_history     (trainHistory),
    .train_pc          (trainPc)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 128; i++) modelPht[i] = 1;
    modelGhr = 0;
  endtask

  // Drives one cycle of inputs just after a rising edge, records the
  // expected prediction, then advances the model to its post-edge state.
  task automatic applyStimulus(input bit pv, input int ppc, input bit tv, input bit tt,
                               input bit tm, input int th, input int tpc);
    bit expTaken;
    int tIdx;
    @(posedge clk);
    #1;
    predictValid      = pv;
    predictPc         = 7'(ppc);
    trainValid        = tv;
    trainTaken        = tt;
    trainMispredicted = tm;
    trainHistory      = 7'(th);
    trainPc           = 7'(tpc);
    expTaken = modelPht[(ppc ^ modelGhr) & 127] >= 2;
    if (pv) expQ.push_back({expTaken, 7'(modelGhr)});
    if (tv) begin
      tIdx = (tpc ^ th) & 127;
      if (tt) modelPht[tIdx] = (modelPht[tIdx] == 3) ? 3 : modelPht[tIdx] + 1;
      else    modelPht[tIdx] = (modelPht[tIdx] == 0) ? 0 : modelPht[tIdx] - 1;
    end
    if (tv && tm)    modelGhr = ((th << 1) | int'(tt)) & 127;
    else if (pv)     modelGhr = ((modelGhr << 1) | int'(expTaken)) & 127;
  endtask

  // Monitor: compares each presented prediction against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (!rst_n && predictValid) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_empty: got prediction with no expectation (t=%0t)", $time);
      end else begin
        exp = expQ.pop_front();
        checkOutput("predict_taken", int'(predictTaken), int'(exp[7]));
        checkOutput("predict_history", int'(predictHistory), int'(exp[6:0]));
      end
    end
  end

  initial begin
    int pc;
    compared          = 0;
    mismatched        = 0;
    predictValid      = 1'b0;
    predictPc         = '0;
    trainValid        = 1'b0;
    trainTaken        = 1'b0;
    trainMispredicted = 1'b0;
    trainHistory      = '0;
    trainPc           = '0;
    modelReset();

    // Reset state: every PC predicts not-taken with zero history.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 128; i += 17) begin
      predictPc = 7'(i);
      #1;
      checkOutput("reset_taken", int'(predictTaken), 0);
      checkOutput("reset_history", int'(predictHistory), 0);
    end
    @(negedge clk);
    rst_n = 1'b0;

    // Directed sequence from the test plan.
    applyStimulus(1, 10, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1, 0, 10);
    applyStimulus(1, 10, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 1, 10);
    applyStimulus(1, 20, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 2, 20);
    applyStimulus(1, 14, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 4, 14);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Saturation on entry 3, observed by predicting the PC that maps onto it.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 0, 0, 3);
    applyStimulus(1, 3 ^ modelGhr, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, 0, 3);
    applyStimulus(1, 3 ^ modelGhr, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 3);
    applyStimulus(1, 3 ^ modelGhr, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0, 3);
    applyStimulus(1, 3 ^ modelGhr, 0, 0, 0, 0, 0);

    // Predict and recovery in the same cycle, then observe the repaired GHR.
    applyStimulus(1, 5, 1, 1, 1, 3, 9);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    // Same-cycle predict and train of the same entry reads the old counter.
    applyStimulus(1, 6 ^ modelGhr, 1, 1, 0, modelGhr, 6);
    applyStimulus(1, 2, 0, 0, 0, 0, 0);

    // Asynchronous reset between clock edges.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("async_reset_history", int'(predictHistory), 0);
    predictPc = 7'(3 ^ 0);
    #1;
    checkOutput("async_reset_taken", int'(predictTaken), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b0;

    // Random traffic over a small PC/history space so entries are revisited.
    for (int n = 0; n < 400; n++) begin
      bit pv, tv, tt, tm;
      pv = ($urandom_range(0, 3) != 0);
      tv = ($urandom_range(0, 1) != 0);
      tt = ($urandom_range(0, 1) != 0);
      tm = ($urandom_range(0, 2) == 0);
      pc = $urandom_range(0, 15);
      applyStimulus(pv, pc, tv, tt, tm, $urandom_range(0, 7), $urandom_range(0, 15));
    end

    @(posedge clk);
    #1;
    predictValid = 1'b0;
    trainValid   = 1'b0;
    @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Gshare conditional-branch direction predictor for the fetch/branch unit.
- Indexes a pattern history table (PHT) of 2-bit saturating counters with PC XOR global history register (GHR).
- Updates the GHR speculatively at prediction time.
- Trains the PHT at resolution, and restores and corrects the GHR on a misprediction.

Parameters:
- PC_BITS, 7, width of predict_pc/train_pc; must equal HIST_BITS.
- HIST_BITS, 7, GHR width; the PHT has 2**HIST_BITS entries.
- CNT_INIT, 2'b01, reset value of every PHT counter (weakly not-taken).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted = 1). Name kept per codebase convention.
- predict_valid  input  1  a prediction is being consumed this cycle.
- predict_pc  input  PC_BITS  PC of the branch being predicted.
- predict_taken  output  1  predicted direction (1 = taken).
- predict_history  output  HIST_BITS  GHR value used for this prediction.
- train_valid  input  1  a resolved branch is being trained this cycle.
- train_taken  input  1  actual resolved direction.
- train_mispredicted  input  1  resolved direction differed from the prediction.
- train_history  input  HIST_BITS  predict_history captured at prediction time.
- train_pc  input  PC_BITS  PC of the resolved branch.

Behaviour:
- State: GHR[HIST_BITS-1:0] and PHT[0..2**HIST_BITS-1] of 2-bit counters. No other state.
- Reset (rst_n=1, asynchronous): GHR=0 and every PHT entry=CNT_INIT.
  - Outputs after reset: predict_history=0, predict_taken=0 for every PC.
- Prediction path is purely combinational, zero latency:
  - pidx = predict_pc ^ GHR.
  - predict_taken = PHT[pidx][1].
  - predict_history = GHR.
  - Outputs are valid regardless of predict_valid.
- Speculative GHR update: at a rising edge with predict_valid=1 and no misprediction recovery, GHR <= {GHR[HIST_BITS-2:0], predict_taken}.
- Training: at a rising edge with train_valid=1:
  - tidx = train_pc ^ train_history.
  - PHT[tidx] increments if train_taken=1, otherwise decrements.
  - The counter saturates at 2'b11 and 2'b00 (no wrap).
- Recovery: train_valid=1 and train_mispredicted=1 gives GHR <= {train_history[HIST_BITS-2:0], train_taken}.
- Same-cycle conflicts:
  - Recovery overrides the speculative update; the simultaneous prediction's shift is discarded.
  - A train without misprediction and a predict together: the PHT is trained and the GHR shifts speculatively.
  - A predict reading the entry being trained that cycle sees the old (pre-edge) counter value.
- train_mispredicted is ignored when train_valid=0. Training without misprediction never touches the GHR.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T. Direction is the MSB.
- Reset asserted mid-operation clears all state immediately; no in-flight update completes.

Test Plan:
1. Reset then predict_pc=10 with predict_valid=1 -> predict_taken=0, predict_history=0; GHR remains 0 after the edge.
2. train_pc=10, train_history=0, taken=1, mispredicted=1 -> PHT[10]=10, GHR=0000001. Then predict_pc=10 -> predict_history=1, index 11, predict_taken=0, GHR=0000010.
3. train pc=10, history=1, taken=0, mispredicted=0 -> PHT[11] goes 01->00, GHR unchanged. Then predict pc=20 -> history=2, index 22, taken=0, GHR=0000100. Train pc=20, history=2, taken=0 -> PHT[22]=00.
4. predict pc=14 with GHR=0000100 -> index 10, predict_taken=1, GHR=0001001. Train pc=14, history=4, taken=0, mispredicted=1 -> PHT[10]=01, GHR=0001000.
5. Saturation: five taken trains on pc=3, history=0 -> PHT[3]=11. Five not-taken trains -> PHT[3]=00 with no wrap.
6. Same-cycle conflict: predict_valid and a mispredicted train with train_history=0000011, taken=1 -> GHR=0000111 (speculative shift discarded). Async reset mid-stream -> GHR=0 without waiting for a clock edge.
